// File: rtl/fixed_cast_pkg.sv
// Shared definitions for the fixed-point cast blocks: symmetric saturation
// limits, widening intermediate width and the shift-direction enum.
package fixed_cast_pkg;

  typedef enum logic [1:0] {
    SHIFT_LEFT,
    SHIFT_RIGHT,
    SHIFT_NONE
  } shift_dir_e;

  // Wide enough that the largest positive exponent never drops a bit.
  function automatic int unsigned ext_width(int unsigned out_w, int unsigned shift_w);
    return out_w + (32'd1 << (shift_w - 1)) - 32'd1;
  endfunction

  function automatic longint sat_pos(int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Symmetric: the most negative code is never produced.
  function automatic longint sat_neg(int unsigned width);
    return -sat_pos(width);
  endfunction

endpackage

// File: rtl/fixed_widen_lane.sv
// One lane of the widening cast: optional round increment, then symmetric
// saturation of the extended value. Rounding enabled by FIXED_WIDEN_ROUND_EN.
module fixed_widen_lane
  import fixed_cast_pkg::*;
#(
  parameter int OUT_WIDTH = 16,
  parameter int EXT       = 23
) (
  input  logic signed [EXT-1:0]       ext_val,
`ifdef FIXED_WIDEN_ROUND_EN
  input  logic                        rnd,
`endif
  output logic        [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  localparam logic signed [EXT:0] POS = (EXT+1)'(sat_pos(OUT_WIDTH));
  localparam logic signed [EXT:0] NEG = (EXT+1)'(sat_neg(OUT_WIDTH));

  logic signed [EXT:0] v;

  always_comb begin
`ifdef FIXED_WIDEN_ROUND_EN
    v = {ext_val[EXT-1], ext_val} + (EXT+1)'(rnd);
`else
    v = {ext_val[EXT-1], ext_val};
`endif
    data = v[OUT_WIDTH-1:0];
    sat  = 1'b0;
    if (v > POS) begin
      data = POS[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end else if (v < NEG) begin
      data = NEG[OUT_WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_widen_stream.sv
// Streaming widening fixed-point cast with runtime exponent and symmetric
// saturation; 2-stage valid/ready pipeline. Macro FIXED_WIDEN_ROUND_EN selects rounding.
module fixed_widen_stream
  import fixed_cast_pkg::*;
#(
  parameter int IN_SIZE        = 8,
  parameter int IN_WIDTH       = 8,
  parameter int IN_FRAC_WIDTH  = 4,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_FRAC_WIDTH = 8,
  parameter int SHIFT_WIDTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]     data_in,
  input  logic signed [SHIFT_WIDTH-1:0]        data_in_shift,
  input  logic                                 data_in_valid,
  output logic                                 data_in_ready,
  output logic [IN_SIZE-1:0][OUT_WIDTH-1:0]    data_out,
  output logic                                 data_out_sat,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int EXT   = int'(ext_width(OUT_WIDTH, SHIFT_WIDTH));
  localparam int ALIGN = OUT_FRAC_WIDTH - IN_FRAC_WIDTH;

  if (OUT_FRAC_WIDTH < IN_FRAC_WIDTH ||
      (OUT_WIDTH - OUT_FRAC_WIDTH) < (IN_WIDTH - IN_FRAC_WIDTH) ||
      IN_FRAC_WIDTH < 0 || OUT_FRAC_WIDTH < 0) begin : g_bad_params
    $error("fixed_widen_stream: output format must contain the input format");
  end

  // Stage 1 combinational: align fraction, then apply the exponent.
  shift_dir_e             dir;
  logic [SHIFT_WIDTH-1:0] amt;
  logic signed [EXT-1:0]  al [IN_SIZE];
  logic signed [EXT-1:0]  sh [IN_SIZE];
`ifdef FIXED_WIDEN_ROUND_EN
  localparam logic [EXT-1:0] ONE = EXT'(1);
  logic [EXT-1:0]         rem, half;
  logic [IN_SIZE-1:0]     rnd_nxt;
`endif

  always_comb begin
    if (data_in_shift == '0)                 dir = SHIFT_NONE;
    else if (data_in_shift[SHIFT_WIDTH-1])   dir = SHIFT_RIGHT;
    else                                     dir = SHIFT_LEFT;
    // Negating the most negative exponent wraps to its correct unsigned magnitude.
    amt = (dir == SHIFT_RIGHT) ? -data_in_shift : data_in_shift;
`ifdef FIXED_WIDEN_ROUND_EN
    rem     = '0;
    half    = '0;
    rnd_nxt = '0;
`endif
    for (int unsigned i = 0; i < IN_SIZE; i++) begin
      al[i] = {{(EXT-IN_WIDTH){data_in[i][IN_WIDTH-1]}}, data_in[i]} <<< ALIGN;
      case (dir)
        SHIFT_LEFT:  sh[i] = al[i] <<< amt;
        SHIFT_RIGHT: sh[i] = al[i] >>> amt;
        default:     sh[i] = al[i];
      endcase
`ifdef FIXED_WIDEN_ROUND_EN
      // Floor already moves negatives away from zero, so an exact half on a
      // negative value needs no increment; only bits below the half do.
      rem  = al[i] & ~({EXT{1'b1}} << amt);
      half = ONE << (amt - SHIFT_WIDTH'(1));
      rnd_nxt[i] = (dir == SHIFT_RIGHT) && ((rem & half) != '0) &&
                   (!al[i][EXT-1] || ((rem & (half - ONE)) != '0));
`endif
    end
  end

  logic                          s1_valid;
  logic [IN_SIZE-1:0][EXT-1:0]   s1_data;
`ifdef FIXED_WIDEN_ROUND_EN
  logic [IN_SIZE-1:0]            s1_rnd;
`endif
  logic                          out_fire, s1_load, s2_load;

  assign out_fire      = data_out_valid & data_out_ready;
  assign s2_load       = s1_valid & (~data_out_valid | out_fire);
  assign data_in_ready = ~s1_valid | s2_load;
  assign s1_load       = data_in_valid & data_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
`ifdef FIXED_WIDEN_ROUND_EN
      s1_rnd   <= '0;
`endif
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      for (int unsigned i = 0; i < IN_SIZE; i++) s1_data[i] <= sh[i];
`ifdef FIXED_WIDEN_ROUND_EN
      s1_rnd   <= rnd_nxt;
`endif
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  logic [IN_SIZE-1:0][OUT_WIDTH-1:0] lane_data;
  logic [IN_SIZE-1:0]                lane_sat;

  for (genvar g = 0; g < IN_SIZE; g++) begin : g_lane
    fixed_widen_lane #(
      .OUT_WIDTH (OUT_WIDTH),
      .EXT       (EXT)
    ) u_lane (
      .ext_val (s1_data[g]),
`ifdef FIXED_WIDEN_ROUND_EN
      .rnd     (s1_rnd[g]),
`endif
      .data    (lane_data[g]),
      .sat     (lane_sat[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_sat   <= 1'b0;
    end else if (s2_load) begin
      data_out_valid <= 1'b1;
      data_out       <= lane_data;
      data_out_sat   <= |lane_sat;
    end else if (out_fire) begin
      data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_widen_stream.sv
// Bench for fixed_widen_stream: directed vectors, backpressure, random traffic
// against an arithmetic reference model, and mid-flight reset.
module tb_fixed_widen_stream;

  localparam int N   = 8;
  localparam int IW  = 8;
  localparam int IFW = 4;
  localparam int OW  = 16;
  localparam int OFW = 8;
  localparam int SW  = 4;
  localparam int NB  = 1000;
  localparam longint LIM = (longint'(1) << (OW-1)) - 1;

  typedef struct packed {
    logic [N-1:0][IW-1:0] d;
    logic signed [SW-1:0] s;
  } beat_t;

  typedef struct packed {
    logic [N-1:0][OW-1:0] d;
    logic                 sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0][IW-1:0] data_in;
  logic signed [SW-1:0] data_in_shift;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [N-1:0][OW-1:0] data_out;
  logic                 data_out_sat;
  logic                 data_out_valid;
  logic                 data_out_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fixed_widen_stream #(
    .IN_SIZE        (N),
    .IN_WIDTH       (IW),
    .IN_FRAC_WIDTH  (IFW),
    .OUT_WIDTH      (OW),
    .OUT_FRAC_WIDTH (OFW),
    .SHIFT_WIDTH    (SW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_shift  (data_in_shift),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_sat   (data_out_sat),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  // Value in units of 2^-OFW, scaled by 2^s, rounded per build, clamped symmetrically.
  function automatic void model_elem(input logic [IW-1:0] x, input int s,
                                     output logic [OW-1:0] y, output logic sat);
    longint v, d, q;
    v = longint'($signed(x)) * (longint'(1) << (OFW - IFW));
    if (s >= 0) begin
      q = v * (longint'(1) << s);
    end else begin
      d = longint'(1) << (-s);
`ifdef FIXED_WIDEN_ROUND_EN
      q = ((v < 0 ? -v : v) + d / 2) / d;
      if (v < 0) q = -q;
`else
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
`endif
    end
    sat = 1'b0;
    if (q > LIM) begin
      q = LIM;
      sat = 1'b1;
    end else if (q < -LIM) begin
      q = -LIM;
      sat = 1'b1;
    end
    y = q[OW-1:0];
  endfunction

  function automatic exp_t model_beat(input beat_t b);
    exp_t e;
    logic [OW-1:0] y;
    logic st;
    e.sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      model_elem(b.d[i], int'(b.s), y, st);
      e.d[i] = y;
      e.sat  = e.sat | st;
    end
    return e;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: b.d[i] = 8'h7F;
          1: b.d[i] = 8'h80;
          2: b.d[i] = 8'h81;
          3: b.d[i] = 8'h00;
          default: b.d[i] = 8'hFF;
        endcase
      end else begin
        b.d[i] = IW'($urandom);
      end
    end
    b.s = SW'($urandom_range(0, 15));
    return b;
  endfunction

  function automatic logic [N-1:0][IW-1:0] mk_in(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                                  input logic [IW-1:0] r);
    logic [N-1:0][IW-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (i == 0) ? a : (i == 1) ? b : r;
    return v;
  endfunction

  function automatic logic [N-1:0][OW-1:0] mk_out(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                                   input logic [OW-1:0] r);
    logic [N-1:0][OW-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (i == 0) ? a : (i == 1) ? b : r;
    return v;
  endfunction

  task automatic send_check(input string name, input beat_t b,
                            input logic [N-1:0][OW-1:0] ed, input logic esat);
    int lat;
    bit found;
    logic [N-1:0][OW-1:0] gd;
    logic gs;
    @(posedge clk); #1;
    data_in = b.d; data_in_shift = b.s; data_in_valid = 1'b1; data_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (data_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready: got %b want 1", name, data_in_ready);
    end
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    lat = 1; found = 1'b0; gd = 'x; gs = 1'bx;
    repeat (8) begin
      @(negedge clk);
      if (data_out_valid === 1'b1) begin
        found = 1'b1; gd = data_out; gs = data_out_sat;
        break;
      end
      @(posedge clk);
      lat++;
    end
    checks++;
    if (!found || lat != 2) begin
      failures++;
      $display("FAIL %s latency: got %0d (found=%b) want 2", name, lat, found);
    end
    checks++;
    if (gd !== ed) begin
      failures++;
      $display("FAIL %s data: got %h want %h", name, gd, ed);
    end
    checks++;
    if (gs !== esat) begin
      failures++;
      $display("FAIL %s sat: got %b want %b", name, gs, esat);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== '0 || data_out_sat !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: got valid=%b data=%h sat=%b want 0/0/0",
               data_out_valid, data_out, data_out_sat);
    end
    checks++;
    if (data_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready: got %b want 1", data_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    beat_t b;
    logic [OW-1:0] rs;
    b.d = mk_in(8'h18, 8'h80, 8'h18); b.s = 4'sd0;
    send_check("pass_through", b, mk_out(16'h0180, 16'hF800, 16'h0180), 1'b0);
    b.d = mk_in(8'h7F, 8'h81, 8'h00); b.s = 4'sd7;
    send_check("sat_both", b, mk_out(16'h7FFF, 16'h8001, 16'h0000), 1'b1);
`ifdef FIXED_WIDEN_ROUND_EN
    rs = 16'h0002;
`else
    rs = 16'h0001;
`endif
    b.d = mk_in(8'h18, 8'hE8, 8'h00); b.s = -4'sd8;
    send_check("right_shift", b, mk_out(rs, 16'hFFFE, 16'h0000), 1'b0);
    b.d = mk_in(8'h80, 8'h7F, 8'h00); b.s = 4'sd4;
    send_check("min_negative", b, mk_out(16'h8001, 16'h7F00, 16'h0000), 1'b1);
  endtask

  task automatic test_back_to_back();
    beat_t bb [3];
    exp_t ee [3];
    int acc;
    bit have;
    logic [N-1:0][OW-1:0] held;
    for (int i = 0; i < 3; i++) begin
      bb[i] = rand_beat();
      ee[i] = model_beat(bb[i]);
    end
    acc = 0; have = 1'b0; held = '0;
    @(posedge clk); #1;
    data_out_ready = 1'b0;
    data_in = bb[0].d; data_in_shift = bb[0].s; data_in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (data_in_valid && data_in_ready) acc++;
      if (data_out_valid) begin
        if (!have) begin
          held = data_out; have = 1'b1;
        end else begin
          checks++;
          if (data_out !== held) begin
            failures++;
            $display("FAIL stall_stable: got %h want %h", data_out, held);
          end
        end
      end
      @(posedge clk); #1;
      if (acc < 3) begin
        data_in = bb[acc].d; data_in_shift = bb[acc].s;
      end
    end
    checks++;
    if (acc != 2 || data_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_accept: got accepted=%0d ready=%b want 2/0", acc, data_in_ready);
    end
    checks++;
    if (!have || held !== ee[0].d) begin
      failures++;
      $display("FAIL stall_head: got %h want %h", held, ee[0].d);
    end
    data_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (data_in_valid && data_in_ready) acc++;
      checks++;
      if (data_out_valid !== 1'b1 || data_out !== ee[k].d || data_out_sat !== ee[k].sat) begin
        failures++;
        $display("FAIL drain_beat%0d: got v=%b %h sat=%b want v=1 %h sat=%b",
                 k, data_out_valid, data_out, data_out_sat, ee[k].d, ee[k].sat);
      end
      @(posedge clk); #1;
      if (acc >= 3) data_in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b0 || acc != 3) begin
      failures++;
      $display("FAIL drain_end: got valid=%b accepted=%0d want 0/3", data_out_valid, acc);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    beat_t cur;
    int sent, recv, cyc;
    bit took;
    sent = 0; recv = 0; cyc = 0; took = 1'b0;
    cur = rand_beat();
    data_in_valid = 1'b0;
    while (recv < NB && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (!data_in_valid || took) begin
        if (sent < NB && $urandom_range(0, 3) != 0) begin
          cur = rand_beat();
          data_in = cur.d; data_in_shift = cur.s; data_in_valid = 1'b1;
        end else begin
          data_in_valid = 1'b0;
        end
      end
      data_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      took = data_in_valid && data_in_ready;
      if (took) begin
        q.push_back(model_beat(cur));
        sent++;
      end
      if (data_out_valid && data_out_ready) begin
        recv++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL random_extra: got unexpected beat %h want none", data_out);
        end else begin
          e = q.pop_front();
          if (data_out !== e.d || data_out_sat !== e.sat) begin
            failures++;
            $display("FAIL random_beat%0d: got %h sat=%b want %h sat=%b",
                     recv, data_out, data_out_sat, e.d, e.sat);
          end
        end
      end
    end
    data_in_valid = 1'b0;
    checks++;
    if (recv != NB || sent != NB || q.size() != 0) begin
      failures++;
      $display("FAIL random_count: got sent=%0d recv=%0d pending=%0d want %0d/%0d/0",
               sent, recv, q.size(), NB, NB);
    end
  endtask

  task automatic test_reset_midflight();
    beat_t b;
    exp_t e;
    int seen;
    @(posedge clk); #1;
    data_out_ready = 1'b0;
    b = rand_beat();
    data_in = b.d; data_in_shift = b.s; data_in_valid = 1'b1;
    @(posedge clk); #1;
    b = rand_beat();
    data_in = b.d; data_in_shift = b.s;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    checks++;
    if (data_out_valid !== 1'b1 || data_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flight_setup: got valid=%b ready=%b want 1/0", data_out_valid, data_in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL async_reset: got valid=%b data=%h want 0/0", data_out_valid, data_out);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (data_in_ready !== 1'b1 || data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_ready: got ready=%b valid=%b want 1/0", data_in_ready, data_out_valid);
    end
    b = rand_beat();
    e = model_beat(b);
    send_check("post_reset_beat", b, e.d, e.sat);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (data_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flushed_beats: got %0d extra valid cycles want 0", seen);
    end
  endtask

  initial begin
    data_in = '0;
    data_in_shift = '0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
